// File: rtl/bridge_rx.sv
// bridge_rx
// Host-side bus initiator. Parses an ASCII command stream from the UART
// receiver into single-cycle requests at the head of the daisy-chained
// register bus.
//
//   Read : 'R' a a a a T
//   Write: 'W' a a a a d d d d T      (hex MSB-first, T = CR or LF)
//
// Ports:
//   clk      in   system clock, posedge
//   rst_n    in   asynchronous active-low reset
//   data_i   in   [7:0]  received byte
//   valid_i  in   data_i valid this cycle
//   addr_o   out  [15:0] request address
//   wdata_o  out  [15:0] request write data (0 for reads)
//   rw_o     out  1 = write, 0 = read
//   valid_o  out  one-cycle request strobe
//   err_o    out  one-cycle pulse on malformed or timed-out command
//
// TIMEOUT_CYCLES: consecutive empty cycles mid-command before the partial
// command is dropped; 0 disables the timeout.

module bridge_rx #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_DIGITS  = 2'd1,
        WRITE_DIGITS = 2'd2,
        AWAIT_TERM   = 2'd3
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1; the expiring cycle is
    // detected by comparison rather than by storing the final count.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters A-F / a-f both have low nibble 1..6, so +9 gives 10..15.
    function automatic logic [3:0] hex_nib(input logic [7:0] b);
        if (b <= 8'h39) return b[3:0];
        else            return b[3:0] + 4'd9;
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

    state_t          state_q;
    logic            is_wr_q;
    logic [2:0]      cnt_q;
    logic [31:0]     asm_q;
    logic [TW-1:0]   idle_cnt_q;
    logic [15:0]     addr_q;
    logic [15:0]     wdata_q;
    logic            rw_q;
    logic            valid_q;
    logic            err_q;

    logic [31:0]     asm_d;
    logic [2:0]      last_digit_d;
    logic            timeout_d;

    always_comb begin
        asm_d        = {asm_q[27:0], hex_nib(data_i)};
        last_digit_d = is_wr_q ? 3'd7 : 3'd3;
        timeout_d    = (TIMEOUT_CYCLES > 0) && (state_q != IDLE) && !valid_i &&
                       (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            cnt_q      <= 3'd0;
            asm_q      <= 32'd0;
            idle_cnt_q <= '0;
            addr_q     <= 16'd0;
            wdata_q    <= 16'd0;
            rw_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (valid_i) begin
                // Any accepted byte restarts the inactivity count, even one
                // arriving on the cycle the count would have expired.
                idle_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (data_i == CH_R) begin
                            asm_q   <= 32'd0;
                            cnt_q   <= 3'd0;
                            is_wr_q <= 1'b0;
                            state_q <= READ_DIGITS;
                        end else if (data_i == CH_W) begin
                            asm_q   <= 32'd0;
                            cnt_q   <= 3'd0;
                            is_wr_q <= 1'b1;
                            state_q <= WRITE_DIGITS;
                        end else if (!is_term(data_i)) begin
                            // Stray CR/LF is tolerated so "\r\n" endings work.
                            err_q <= 1'b1;
                        end
                    end
                    READ_DIGITS, WRITE_DIGITS: begin
                        if (is_hex(data_i)) begin
                            asm_q <= asm_d;
                            if (cnt_q == last_digit_d) state_q <= AWAIT_TERM;
                            else                       cnt_q   <= cnt_q + 3'd1;
                        end else begin
                            // Includes an early terminator and a new 'R'/'W':
                            // the offending byte is dropped, not re-parsed.
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    AWAIT_TERM: begin
                        if (is_term(data_i)) begin
                            valid_q <= 1'b1;
                            rw_q    <= is_wr_q;
                            if (is_wr_q) begin
                                addr_q  <= asm_q[31:16];
                                wdata_q <= asm_q[15:0];
                            end else begin
                                addr_q  <= asm_q[15:0];
                                wdata_q <= 16'd0;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (timeout_d) begin
                    err_q      <= 1'b1;
                    state_q    <= IDLE;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + TW'(1);
                end
            end else begin
                idle_cnt_q <= '0;
            end
        end
    end

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Directed bench for bridge_rx with TIMEOUT_CYCLES = 10.
// Each string is sent one byte per cycle; after every edge the valid_o and
// err_o values are captured into per-byte bit patterns (bit i = response to
// byte i) and compared against hand-computed patterns.

module tb_bridge_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        valid_i = 1'b0;
    logic [15:0] addr_o;
    logic [15:0] wdata_o;
    logic        rw_o;
    logic        valid_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] v_pat;
    logic [31:0] e_pat;

    always #5 clk = ~clk;

    bridge_rx #(.TIMEOUT_CYCLES(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rw_o    (rw_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_str(input string s);
        v_pat = '0;
        e_pat = '0;
        for (int i = 0; i < s.len(); i++) begin
            data_i  = s[i];
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            v_pat[i] = valid_o;
            e_pat[i] = err_o;
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic gap(input int n);
        v_pat = '0;
        e_pat = '0;
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            v_pat[i] = valid_o;
            e_pat[i] = err_o;
        end
    endtask

    // valid_o and err_o must never coincide.
    always @(negedge clk) begin
        if (rst_n) check("excl", {31'd0, valid_o & err_o}, 32'd0);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",  {16'd0, addr_o},  32'd0);
        check("rst_wdata", {16'd0, wdata_o}, 32'd0);
        check("rst_rw",    {31'd0, rw_o},    32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_err",   {31'd0, err_o},   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read; LF (byte 6) produces nothing.
        send_str("R1234\r\n");
        check("rd_vpat", v_pat, 32'h20);
        check("rd_epat", e_pat, 32'h0);
        check("rd_addr", {16'd0, addr_o},  32'h1234);
        check("rd_rw",   {31'd0, rw_o},    32'd0);
        check("rd_wdat", {16'd0, wdata_o}, 32'd0);

        // Write with mixed-case hex.
        send_str("W00ABbeef\r");
        check("wr_vpat", v_pat, 32'h200);
        check("wr_epat", e_pat, 32'h0);
        check("wr_addr", {16'd0, addr_o},  32'h00AB);
        check("wr_wdat", {16'd0, wdata_o}, 32'hBEEF);
        check("wr_rw",   {31'd0, rw_o},    32'd1);
        gap(3);
        check("hold_vpat", v_pat, 32'h0);
        check("hold_addr", {16'd0, addr_o},  32'h00AB);
        check("hold_wdat", {16'd0, wdata_o}, 32'hBEEF);
        check("hold_rw",   {31'd0, rw_o},    32'd1);

        // Malformed: err on 'G', then '4' and CR... '4' errs in IDLE, CR ignored.
        send_str("R12G4\r");
        check("bad_vpat", v_pat, 32'h0);
        check("bad_epat", e_pat, 32'h18);
        send_str("R0005\n");
        check("rec_vpat", v_pat, 32'h20);
        check("rec_epat", e_pat, 32'h0);
        check("rec_addr", {16'd0, addr_o},  32'h0005);
        check("rec_wdat", {16'd0, wdata_o}, 32'd0);
        check("rec_rw",   {31'd0, rw_o},    32'd0);

        // Wrong lengths.
        send_str("R123\r");
        check("short_v", v_pat, 32'h0);
        check("short_e", e_pat, 32'h10);
        send_str("R12345\r");
        check("long_v", v_pat, 32'h0);
        check("long_e", e_pat, 32'h20);
        send_str("W1234\r");
        check("wshort_v", v_pat, 32'h0);
        check("wshort_e", e_pat, 32'h20);
        check("keep_addr", {16'd0, addr_o}, 32'h0005);

        // Timeout: 9-cycle gap survives.
        send_str("W12");
        check("to9_e0", e_pat, 32'h0);
        gap(9);
        check("to9_gap", e_pat, 32'h0);
        send_str("3400FF\r");
        check("to9_v",    v_pat, 32'h40);
        check("to9_e",    e_pat, 32'h0);
        check("to9_addr", {16'd0, addr_o},  32'h1234);
        check("to9_wdat", {16'd0, wdata_o}, 32'h00FF);
        check("to9_rw",   {31'd0, rw_o},    32'd1);

        // Timeout: 10-cycle gap expires on its last cycle, exactly once.
        send_str("W12");
        gap(13);
        check("to10_e", e_pat, 32'h200);
        check("to10_v", v_pat, 32'h0);
        send_str("R0001\r");
        check("to10_rv",   v_pat, 32'h20);
        check("to10_re",   e_pat, 32'h0);
        check("to10_addr", {16'd0, addr_o}, 32'h0001);
        check("to10_rw",   {31'd0, rw_o},   32'd0);

        // Reset mid-command, asserted away from the clock edge.
        send_str("W1234");
        rst_n = 1'b0;
        #1;
        check("mrst_addr",  {16'd0, addr_o},  32'd0);
        check("mrst_valid", {31'd0, valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mrst_wdata", {16'd0, wdata_o}, 32'd0);
        check("mrst_rw",    {31'd0, rw_o},    32'd0);
        check("mrst_err",   {31'd0, err_o},   32'd0);
        rst_n = 1'b1;
        send_str("R0002\r");
        check("post_v",    v_pat, 32'h20);
        check("post_e",    e_pat, 32'h0);
        check("post_addr", {16'd0, addr_o},  32'h0002);
        check("post_rw",   {31'd0, rw_o},    32'd0);
        check("post_wdat", {16'd0, wdata_o}, 32'd0);

        gap(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
